pipe_fifo: RTL
==============

Name: pipe_fifo

Overview:
Parametrised synchronous FIFO. It is the buffered successor to the single-entry enable/clear pipeline flops: DEPTH entries of WIDTH bits instead of one.
- Used between pipeline stages that stall independently, e.g. fetch-to-decode queue and store buffer.
- Show-ahead read port, push/pop handshake, synchronous flush, occupancy count.

Parameters:
WIDTH, 32, data bits per entry.
DEPTH, 4, number of entries; power of two, minimum 2.
AW, $clog2(DEPTH), localparam; pointer width, not overridable.

Ports:
clk  input  1  single clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush.
wr_en  input  1  push request.
din  input  WIDTH  push data.
rd_en  input  1  pop request.
dout  output  WIDTH  head entry (show-ahead).
empty  output  1  no valid entries.
full  output  1  DEPTH valid entries.
count  output  AW+1  occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Reset asserts immediately and releases synchronously to clk.
- State: storage array mem[DEPTH], wptr/rptr (AW bits each), count (AW+1 bits). empty = (count==0); full = (count==DEPTH). Both are decoded from count, with no separate state.
- Reset, asynchronous, takes effect without a clock edge: wptr=rptr=0, count=0, every mem entry=0. Resulting outputs: empty=1, full=0, dout=0.
- Accept rules, evaluated on pre-edge state:
  - pop_ok = rd_en & ~empty
  - push_ok = wr_en & (~full | pop_ok)
- Edge update:
  - push_ok: mem[wptr]<=din, wptr<=wptr+1.
  - pop_ok: rptr<=rptr+1.
  - count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointer arithmetic: pointers wrap modulo DEPTH, DEPTH-1 -> 0, through natural AW-bit overflow. count never wraps.
- dout = mem[rptr], combinational from storage.
  - Latency: data pushed at edge N is on dout and empty=0 after edge N.
  - dout while empty is don't-care; the bench must not check it, except after reset, where it is 0.
- Boundary cases:
  - Push while full with no pop: dropped. State unchanged, no error.
  - Pop while empty: ignored.
  - Push+pop while full: both accepted; count stays DEPTH, head advances.
  - Push+pop while empty: push only; count becomes 1, dout=din after the edge.
- clear: takes priority over push/pop in the same cycle. Sets wptr=rptr=count=0 at the edge; mem contents are not cleared.
- Reset mid-operation: discards all contents asynchronously, regardless of clear, wr_en or rd_en.

Optional Feature:
PIPE_FIFO_ERR_EN.
- Defined: adds output ports overflow (1) and underflow (1), both sticky.
  - overflow sets at the edge where wr_en & full & ~pop_ok.
  - underflow sets at the edge where rd_en & empty.
  - Both are cleared by reset (asynchronously) or clear (synchronously); clear wins over a same-cycle set.
- Undefined: the ports do not exist; illegal push/pop is silently ignored as above.

Decomposition:
- No new package types. Add one function to the shared components package: clog2 for pointer sizing, reused by other parametrised blocks.
- One sub-module, fifo_ptr #(AW): wrapping pointer register with async reset, sync clear and increment enable. Instantiated twice, as wptr and rptr.
- Storage array, count and flag logic stay in pipe_fifo.

Test Plan:
- Reset with DEPTH=4, WIDTH=32 -> empty=1, full=0, count=0, dout=0 with no clock edge.
- Push 0xA0..0xA3 on 4 consecutive cycles -> count 1,2,3,4. full=1 after the 4th edge. A 5th push of 0xA4 is dropped (overflow=1 with PIPE_FIFO_ERR_EN).
- Full, then push 0xB0 and pop together -> dout 0xA1, count=4. Then pop 4 times -> dout sequence 0xA1,0xA2,0xA3,0xB0, exercising wrap-around, then empty=1.
- Empty, push 0x55 and pop together -> count=1, dout=0x55. Pop on an empty FIFO -> no state change (underflow=1 with the macro).
- Three entries queued, clear with push 0x77 in the same cycle -> count=0, empty=1, push ignored. A following push of 0x88 -> dout=0x88.
- Assert reset mid-stream, asynchronously between edges, with count=2 -> count=0, empty=1 immediately. Operation resumes normally after release.

Source files
------------

// File: rtl/pipe_fifo_pkg.sv
// Shared components package: helpers reused by parametrised blocks.
package pipe_fifo_pkg;

  // Ceiling log2 usable in parameter expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW-bit pointer register with async reset, sync clear and increment enable.
module fifo_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // Wrap from DEPTH-1 to 0 comes from natural AW-bit overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_fifo.sv
// Synchronous show-ahead FIFO with push/pop handshake, flush and occupancy count.
// Define PIPE_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module pipe_fifo
  import pipe_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
`ifdef PIPE_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam logic [AW:0] DEPTH_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_COUNT);
  assign pop_ok  = rd_en & ~empty;
  // A full FIFO still takes a push when the same edge frees the head slot.
  assign push_ok = wr_en & (~full | pop_ok);
  assign dout    = mem[rptr];

  fifo_ptr #(.AW(AW)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (push_ok),
    .ptr   (wptr)
  );

  fifo_ptr #(.AW(AW)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (pop_ok),
    .ptr   (rptr)
  );

  // NOTE: storage is reset on purpose so dout reads 0 straight out of reset;
  // this keeps mem in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok && !clear) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_FIFO_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !pop_ok) overflow  <= 1'b1;
      if (rd_en && empty)           underflow <= 1'b1;
    end
  end
`endif

endmodule
